// File: rtl/capture_buffer_ctrl_if.sv
// capture_buffer_ctrl_if: write/read port bundle between the
// capture controller (master) and the capture buffer (slave).
interface capture_buffer_ctrl_if #(
  parameter int index_bits = 4,
  parameter int i_bits     = 12,
  parameter int q_bits     = 12
);
  logic [index_bits-1:0]    m_axi_waddr;
  logic [i_bits+q_bits-1:0] m_axi_wdata;
  logic                     m_axi_wvalid;
  logic                     s_axi_wready;
  logic                     s_axi_bvalid;
  logic [index_bits-1:0]    m_axi_raddr;
  logic                     m_axi_rvalid;
  logic                     m_axi_rready;
  logic                     s_axi_rready;
  logic                     s_axi_rvalid;
  logic signed [i_bits-1:0] s_i;
  logic signed [q_bits-1:0] s_q;

  modport master (
    output m_axi_waddr, m_axi_wdata, m_axi_wvalid,
    output m_axi_raddr, m_axi_rvalid, m_axi_rready,
    input  s_axi_wready, s_axi_bvalid,
    input  s_axi_rready, s_axi_rvalid, s_i, s_q
  );

  modport slave (
    input  m_axi_waddr, m_axi_wdata, m_axi_wvalid,
    input  m_axi_raddr, m_axi_rvalid, m_axi_rready,
    output s_axi_wready, s_axi_bvalid,
    output s_axi_rready, s_axi_rvalid, s_i, s_q
  );
endinterface

// File: rtl/capture_buffer_ctrl.sv
// capture_buffer_ctrl: captures a sample burst into the buffer and reads it back.
// Optional response watchdog enabled by defining CAPTURE_TIMEOUT_EN.
module capture_buffer_ctrl #(
  parameter int buffer_length  = 10,
  parameter int index_bits     = 4,
  parameter int i_bits         = 12,
  parameter int q_bits         = 12,
  parameter int timeout_cycles = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     read_start,
  input  logic signed [i_bits-1:0] sample_i,
  input  logic signed [q_bits-1:0] sample_q,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  capture_buffer_ctrl_if.master    bus,
  output logic signed [i_bits-1:0] out_i,
  output logic signed [q_bits-1:0] out_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     capture_done,
  output logic                     read_done,
  output logic                     error
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_OUT
  } state_t;

  localparam logic [index_bits-1:0] LAST =
    index_bits'(buffer_length - 1);

  state_t                state;
  logic [index_bits-1:0] addr;
  logic                  last;

  assign last         = (addr == LAST);
  assign busy         = (state != IDLE);
  assign sample_ready = (state == WR_REQ) && bus.s_axi_wready;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic          error_q;
  assign tmo   = (tcnt == TW'(timeout_cycles - 1));
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Transaction sequencer with registered request/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      addr             <= '0;
      bus.m_axi_waddr  <= '0;
      bus.m_axi_wdata  <= '0;
      bus.m_axi_wvalid <= 1'b0;
      bus.m_axi_raddr  <= '0;
      bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rready <= 1'b0;
      out_i            <= '0;
      out_q            <= '0;
      out_valid        <= 1'b0;
      capture_done     <= 1'b0;
      read_done        <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      tcnt             <= '0;
      error_q          <= 1'b0;
`endif
    end else begin
      bus.m_axi_wvalid <= 1'b0;
      bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rready <= 1'b0;
      capture_done     <= 1'b0;
      read_done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || read_start) begin
            addr  <= '0;
            state <= start ? WR_REQ : RD_REQ;
`ifdef CAPTURE_TIMEOUT_EN
            error_q <= 1'b0;
`endif
          end
        end
        WR_REQ: begin
          if (sample_valid && bus.s_axi_wready) begin
            bus.m_axi_wvalid <= 1'b1;
            bus.m_axi_waddr  <= addr;
            bus.m_axi_wdata  <= {sample_i, sample_q};
            state            <= WR_WAIT;
`ifdef CAPTURE_TIMEOUT_EN
            tcnt             <= '0;
`endif
          end
        end
        WR_WAIT: begin
          if (bus.s_axi_bvalid) begin
            if (last) begin
              capture_done <= 1'b1;
              state        <= IDLE;
            end else begin
              addr  <= addr + 1'b1;
              state <= WR_REQ;
            end
          end
`ifdef CAPTURE_TIMEOUT_EN
          else if (tmo) begin
            error_q <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RD_REQ: begin
          if (bus.s_axi_rready) begin
            bus.m_axi_rvalid <= 1'b1;
            bus.m_axi_rready <= 1'b1;
            bus.m_axi_raddr  <= addr;
            state            <= RD_WAIT;
`ifdef CAPTURE_TIMEOUT_EN
            tcnt             <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (bus.s_axi_rvalid) begin
            out_i     <= bus.s_i;
            out_q     <= bus.s_q;
            out_valid <= 1'b1;
            state     <= RD_OUT;
          end
`ifdef CAPTURE_TIMEOUT_EN
          else if (tmo) begin
            error_q <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RD_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              read_done <= 1'b1;
              state     <= IDLE;
            end else begin
              addr  <= addr + 1'b1;
              state <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
